// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit: opcodes,
// FSM states, ALU operand/operation encodings and the control word layout.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        ALU_WB,
        BRANCH,
        TRAP
    } state_t;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
    } ctrl_word_t;

    // Instruction class dispatch out of DECODE; unknown opcodes trap.
    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_RTYPE:           return EXEC_R;
            OP_ITYPE:           return EXEC_I;
            OP_LOAD, OP_STORE:  return MEM_ADDR;
            OP_BRANCH:          return BRANCH;
            default:            return TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_ctrl_word_decode.sv
// Combinational state -> control word map. Only FETCH depends on mem_ready
// (IR and PC are loaded in the cycle the instruction word arrives).
module ctrl_word_decode
    import riscv_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_word_t cw
);

    // Everything defaults to 0; each state raises only its own controls.
    always_comb begin
        cw = '0;
        case (state)
            FETCH: begin
                cw.mem_read  = 1'b1;
                cw.alu_src_b = SRCB_FOUR;
                cw.alu_op    = ALUOP_ADD;
                cw.ir_write  = mem_ready;
                cw.pc_write  = mem_ready;
            end
            DECODE: begin
                // PC + imm lands in ALUOut as the branch target
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_ADD;
            end
            EXEC_R: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_RS2;
                cw.alu_op    = ALUOP_RFUNCT;
            end
            EXEC_I: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_IFUNCT;
            end
            MEM_ADDR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_ADD;
            end
            MEM_RD: begin
                cw.iord     = 1'b1;
                cw.mem_read = 1'b1;
            end
            MEM_WB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                cw.iord      = 1'b1;
                cw.mem_write = 1'b1;
            end
            ALU_WB: begin
                cw.reg_write = 1'b1;
            end
            BRANCH: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_RS2;
                cw.alu_op    = ALUOP_SUB;
                cw.branch    = 1'b1;
                cw.pc_source = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// latches the opcode in DECODE, traps on unknown opcodes and counts
// retired instructions.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUOP_W       = 2,
    parameter int USE_MEM_READY = 1,
    parameter int CNT_W         = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               Branch,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               PCSource,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    state_t           state_reg;
    logic [6:0]       opcode_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             ready_eff;
    logic             retire;
    ctrl_word_t       cw;
    ctrl_word_t       cw_out;

    // zero only gates Branch inside the datapath; the FSM never needs it.
    logic unused_zero;
    assign unused_zero = zero;

    assign ready_eff = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    // A retire cycle is the last cycle of a completed instruction.
    always_comb begin
        retire = 1'b0;
        case (state_reg)
            ALU_WB, MEM_WB, BRANCH: retire = 1'b1;
            MEM_WR:                 retire = ready_eff;
            default:                retire = 1'b0;
        endcase
    end

    // Main FSM plus opcode latch, sticky trap flag and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= FETCH;
            opcode_reg  <= '0;
            illegal_reg <= 1'b0;
            retired_reg <= '0;
        end else begin
            if (retire)
                retired_reg <= retired_reg + CNT_W'(1);
            case (state_reg)
                FETCH:  if (ready_eff) state_reg <= DECODE;
                DECODE: begin
                    opcode_reg <= opcode;
                    state_reg  <= decode_next(opcode);
                    if (decode_next(opcode) == TRAP)
                        illegal_reg <= 1'b1;
                end
                EXEC_R, EXEC_I: state_reg <= ALU_WB;
                MEM_ADDR: state_reg <= (opcode_reg == OP_LOAD) ? MEM_RD : MEM_WR;
                MEM_RD: if (ready_eff) state_reg <= MEM_WB;
                MEM_WR: if (ready_eff) state_reg <= FETCH;
                MEM_WB, ALU_WB, BRANCH: state_reg <= FETCH;
                TRAP:    state_reg <= TRAP;
                default: state_reg <= FETCH;
            endcase
        end
    end

    ctrl_word_decode u_ctrl_word_decode (
        .state     (state_reg),
        .mem_ready (ready_eff),
        .cw        (cw)
    );

    // Controls are held at 0 for as long as reset is asserted.
    always_comb begin
        cw_out = reset ? '0 : cw;
    end

    assign PCWrite  = cw_out.pc_write;
    assign Branch   = cw_out.branch;
    assign IorD     = cw_out.iord;
    assign MemRead  = cw_out.mem_read;
    assign MemWrite = cw_out.mem_write;
    assign IRWrite  = cw_out.ir_write;
    assign MemtoReg = cw_out.mem_to_reg;
    assign RegWrite = cw_out.reg_write;
    assign ALUSrcA  = cw_out.alu_src_a;
    assign ALUSrcB  = cw_out.alu_src_b;
    assign ALUOp    = ALUOP_W'(cw_out.alu_op);
    assign PCSource = cw_out.pc_source;
    assign illegal  = illegal_reg;
    assign retired  = retired_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. Each instruction is expanded into the
// per-cycle control-word trace the instruction set implies (including wait
// cycles chosen up front), then replayed against the DUT cycle by cycle.
module tb_multicycle_control_unit;

    localparam logic [6:0] T_R = 7'b0110011;
    localparam logic [6:0] T_I = 7'b0010011;
    localparam logic [6:0] T_L = 7'b0000011;
    localparam logic [6:0] T_S = 7'b0100011;
    localparam logic [6:0] T_B = 7'b1100011;
    localparam logic [6:0] T_X = 7'b1111111;

    // Control vector layout:
    // {PCWrite,Branch,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    function automatic logic [13:0] mk(input bit pcw, br, iord, mrd, mwr, irw, m2r, rw, sa,
                                       input logic [1:0] sb, aop, input bit pcs);
        return {pcw, br, iord, mrd, mwr, irw, m2r, rw, sa, sb, aop, pcs};
    endfunction

    localparam logic [13:0] C_ZERO  = 14'd0;
    localparam logic [13:0] C_FWAIT = mk(0,0,0,1,0,0,0,0,0,2'b01,2'b00,0);
    localparam logic [13:0] C_FGO   = mk(1,0,0,1,0,1,0,0,0,2'b01,2'b00,0);
    localparam logic [13:0] C_DEC   = mk(0,0,0,0,0,0,0,0,0,2'b10,2'b00,0);
    localparam logic [13:0] C_EXR   = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,0);
    localparam logic [13:0] C_EXI   = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b11,0);
    localparam logic [13:0] C_AWB   = mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,0);
    localparam logic [13:0] C_MA    = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,0);
    localparam logic [13:0] C_MRD   = mk(0,0,1,1,0,0,0,0,0,2'b00,2'b00,0);
    localparam logic [13:0] C_MWB   = mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,0);
    localparam logic [13:0] C_MWR   = mk(0,0,1,0,1,0,0,0,0,2'b00,2'b00,0);
    localparam logic [13:0] C_BR    = mk(0,1,0,0,0,0,0,0,1,2'b00,2'b01,1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT (defaults) and a narrow-counter DUT that ignores mem_ready
    logic       reset, zero, mem_ready;
    logic [6:0] opcode;
    logic       reset2, zero2, mem_ready2;
    logic [6:0] opcode2;

    logic       pcw1, br1, iord1, mrd1, mwr1, irw1, m2r1, rw1, sa1, pcs1, ill1;
    logic [1:0] sb1, aop1;
    logic [31:0] ret1;
    logic       pcw2, br2, iord2, mrd2, mwr2, irw2, m2r2, rw2, sa2, pcs2, ill2;
    logic [1:0] sb2, aop2;
    logic [3:0] ret2;
    logic [13:0] cw1, cw2;

    assign cw1 = {pcw1, br1, iord1, mrd1, mwr1, irw1, m2r1, rw1, sa1, sb1, aop1, pcs1};
    assign cw2 = {pcw2, br2, iord2, mrd2, mwr2, irw2, m2r2, rw2, sa2, sb2, aop2, pcs2};

    multicycle_control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(pcw1), .Branch(br1), .IorD(iord1), .MemRead(mrd1), .MemWrite(mwr1),
        .IRWrite(irw1), .MemtoReg(m2r1), .RegWrite(rw1), .ALUSrcA(sa1), .ALUSrcB(sb1),
        .ALUOp(aop1), .PCSource(pcs1), .illegal(ill1), .retired(ret1)
    );

    multicycle_control_unit #(.ALUOP_W(2), .USE_MEM_READY(0), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset2), .opcode(opcode2), .zero(zero2), .mem_ready(mem_ready2),
        .PCWrite(pcw2), .Branch(br2), .IorD(iord2), .MemRead(mrd2), .MemWrite(mwr2),
        .IRWrite(irw2), .MemtoReg(m2r2), .RegWrite(rw2), .ALUSrcA(sa2), .ALUSrcB(sb2),
        .ALUOp(aop2), .PCSource(pcs2), .illegal(ill2), .retired(ret2)
    );

    typedef struct {
        logic [13:0] cw;
        bit          mr;
        bit          dec;
        bit          ret;
        bit          ill;
    } step_t;

    step_t trace[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    exp_ret1 = 0;
    int    exp_ret2 = 0;
    bit    sel      = 1'b0;

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic step_t st(input logic [13:0] cw, input bit mr, dec, ret, ill);
        step_t s;
        s.cw = cw; s.mr = mr; s.dec = dec; s.ret = ret; s.ill = ill;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] op, input bit mr, input bit z);
        if (!sel) begin opcode = op;  mem_ready = mr;  zero = z;  end
        else      begin opcode2 = op; mem_ready2 = mr; zero2 = z; end
    endtask

    function automatic logic [13:0] obs_cw();
        return sel ? cw2 : cw1;
    endfunction
    function automatic logic [31:0] obs_ret();
        return sel ? {28'd0, ret2} : ret1;
    endfunction
    function automatic logic [31:0] want_ret();
        return sel ? 32'(exp_ret2 & 15) : 32'(exp_ret1);
    endfunction
    function automatic logic obs_ill();
        return sel ? ill2 : ill1;
    endfunction

    // Expected cycle trace for one instruction. fw = fetch wait cycles,
    // mw = wait cycles in the memory access state. The narrow DUT ignores
    // mem_ready, so there every state is a single cycle and mem_ready is noise.
    task automatic build(input logic [6:0] opc, input int fw, input int mw);
        trace.delete();
        for (int i = 0; i < fw; i++) trace.push_back(st(C_FWAIT, 1'b0, 0, 0, 0));
        trace.push_back(st(C_FGO, sel ? rb() : 1'b1, 0, 0, 0));
        trace.push_back(st(C_DEC, rb(), 1, 0, 0));
        case (opc)
            T_R: begin
                trace.push_back(st(C_EXR, rb(), 0, 0, 0));
                trace.push_back(st(C_AWB, rb(), 0, 1, 0));
            end
            T_I: begin
                trace.push_back(st(C_EXI, rb(), 0, 0, 0));
                trace.push_back(st(C_AWB, rb(), 0, 1, 0));
            end
            T_L: begin
                trace.push_back(st(C_MA, rb(), 0, 0, 0));
                for (int i = 0; i < mw; i++) trace.push_back(st(C_MRD, 1'b0, 0, 0, 0));
                trace.push_back(st(C_MRD, sel ? rb() : 1'b1, 0, 0, 0));
                trace.push_back(st(C_MWB, rb(), 0, 1, 0));
            end
            T_S: begin
                trace.push_back(st(C_MA, rb(), 0, 0, 0));
                for (int i = 0; i < mw; i++) trace.push_back(st(C_MWR, 1'b0, 0, 0, 0));
                trace.push_back(st(C_MWR, sel ? rb() : 1'b1, 0, 1, 0));
            end
            T_B: trace.push_back(st(C_BR, rb(), 0, 1, 0));
            default: begin
                for (int i = 0; i < 12; i++) trace.push_back(st(C_ZERO, rb(), 0, 0, 1));
            end
        endcase
    endtask

    // Replays the first n trace steps; opcode input is garbage outside DECODE.
    task automatic play(input logic [6:0] opc, input int n);
        for (int i = 0; i < n && i < trace.size(); i++) begin
            logic [6:0] op_drv;
            string      who;
            op_drv = trace[i].dec ? opc : 7'($urandom_range(0, 127));
            who    = sel ? "dut4" : "dut";
            set_in(op_drv, trace[i].mr, rb());
            #1;
            check($sformatf("%s op=%b cyc%0d ctrl", who, opc, i), 32'(obs_cw()), 32'(trace[i].cw));
            check($sformatf("%s op=%b cyc%0d retired", who, opc, i), obs_ret(), want_ret());
            check($sformatf("%s op=%b cyc%0d illegal", who, opc, i), 32'(obs_ill()), 32'(trace[i].ill));
            @(posedge clk); #1;
            if (trace[i].ret) begin
                if (sel) exp_ret2++;
                else     exp_ret1++;
            end
        end
    endtask

    task automatic run(input logic [6:0] opc, input int fw, input int mw);
        build(opc, fw, mw);
        play(opc, trace.size());
    endtask

    // Holds the selected DUT in reset for n cycles, checking the forced-zero outputs.
    task automatic do_reset(input int n);
        if (!sel) reset = 1'b1; else reset2 = 1'b1;
        for (int i = 0; i < n; i++) begin
            set_in(7'($urandom_range(0, 127)), 1'b1, rb());
            #1;
            check($sformatf("reset%0d ctrl", i), 32'(obs_cw()), 32'(C_ZERO));
            @(posedge clk); #1;
            check($sformatf("reset%0d ctrl after edge", i), 32'(obs_cw()), 32'(C_ZERO));
            check($sformatf("reset%0d retired", i), obs_ret(), 32'd0);
            check($sformatf("reset%0d illegal", i), 32'(obs_ill()), 32'd0);
        end
        if (!sel) begin reset = 1'b0; exp_ret1 = 0; end
        else      begin reset2 = 1'b0; exp_ret2 = 0; end
    endtask

    initial begin
        logic [6:0] ops [5];
        ops[0] = T_R; ops[1] = T_I; ops[2] = T_L; ops[3] = T_S; ops[4] = T_B;
        reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        reset2 = 1'b1; opcode2 = '0; zero2 = 1'b0; mem_ready2 = 1'b0;

        sel = 1'b0;
        do_reset(3);

        // R-type, 4 cycles, retired 0 -> 1
        run(T_R, 0, 0);
        check("after R retired", ret1, 32'd1);

        // load with 3 wait cycles in MEM_RD: 8 cycles total
        run(T_L, 0, 3);
        check("after load retired", ret1, 32'd2);

        // store then branch: 7 cycles, +2 retired
        run(T_S, 0, 0);
        run(T_B, 0, 0);
        check("after store+branch retired", ret1, 32'd4);

        // mixed random instructions with random fetch / memory waits
        for (int k = 0; k < 20; k++)
            run(ops[$urandom_range(0, 4)], $urandom_range(0, 2), $urandom_range(0, 3));

        // illegal opcode: trap, sticky, nothing retired; reset clears it
        run(T_X, $urandom_range(0, 1), 0);
        check("trap retired unchanged", ret1, 32'(exp_ret1));
        do_reset(2);
        run(T_B, 0, 0);
        check("post-trap branch retired", ret1, 32'd1);

        // reset while waiting in MEM_RD: no partial retire, restart in FETCH
        build(T_L, 0, 10);
        play(T_L, 6);
        do_reset(2);
        run(T_R, 1, 0);
        check("post-abort retired", ret1, 32'd1);

        // narrow counter, mem_ready ignored: 18 back-to-back I-types wrap 15 -> 0
        reset = 1'b1;
        sel = 1'b1;
        do_reset(2);
        for (int k = 0; k < 18; k++) run(T_I, 0, 0);
        check("dut4 wrapped retired", {28'd0, ret2}, 32'd2);
        run(T_L, 0, 0);
        run(T_S, 0, 0);
        check("dut4 final retired", {28'd0, ret2}, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Successor to the single-cycle RISC-V control unit, for the multi-cycle datapath.
- A Moore FSM sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives one control word per cycle.
- Adds I-type ALU support, a memory-ready handshake, a sticky illegal-opcode trap and a parametrised retired-instruction counter.
- Sits between the instruction register / unified memory and the shared ALU/regfile datapath.

Parameters:
- ALUOP_W, 2: width of ALUOp (00 add, 01 sub/compare, 10 funct-decoded R, 11 funct-decoded I).
- USE_MEM_READY, 1: 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0] from the instruction register; sampled in DECODE only.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC update.
- Branch  out  1  PC update qualified by zero (the datapath ANDs Branch with zero).
- IorD  out  1  memory address source: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  writeback source: 1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register-file write.
- ALUSrcA  out  1  0 = PC, 1 = rs1.
- ALUSrcB  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- ALUOp  out  ALUOP_W  ALU operation class.
- PCSource  out  1  0 = ALU result, 1 = ALUOut (branch target).
- illegal  out  1  sticky trap flag.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset:
  - state <= FETCH, retired <= 0, illegal <= 0.
  - While reset is high, all control outputs are forced to 0. The first active FETCH cycle is the cycle after reset deasserts.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, TRAP.
- Outputs are a function of state only, except where a term is qualified by mem_ready as noted below.
- Any control not listed for a state is 0.
- FETCH:
  - IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - IRWrite=PCWrite=mem_ready.
  - Go to DECODE when mem_ready is high, else stay.
- DECODE:
  - ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target precomputed into ALUOut).
  - Next state by opcode: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011/0100011 -> MEM_ADDR; 1100011 -> BRANCH; any other -> TRAP.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11; -> ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0; retire; -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state uses the opcode latched in DECODE: load -> MEM_RD, store -> MEM_WR.
- MEM_RD: IorD=1, MemRead=1; -> MEM_WB on mem_ready, else stay.
- MEM_WB: RegWrite=1, MemtoReg=1; retire; -> FETCH.
- MEM_WR: IorD=1, MemWrite=1; on mem_ready retire and -> FETCH, else stay.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSource=1; retire; -> FETCH.
  - Branch is asserted whether or not the branch is taken.
- TRAP:
  - All controls 0; illegal=1.
  - Stays in TRAP until reset; no retire.
- Opcode latching: the opcode is captured into an internal register in DECODE. Changes on the opcode input outside DECODE have no effect.
- Retire counter:
  - retired increments by 1 on each retire cycle.
  - Wraps modulo 2^CNT_W with no saturation.
- mem_ready held low in a waiting state: the FSM holds indefinitely and keeps its outputs stable (MemRead/MemWrite stay high).
- USE_MEM_READY=0: every waiting state is exactly one cycle.
- Reset mid-instruction (any state, including TRAP): the next cycle is FETCH with outputs zero during reset. No partial retire is counted.
- Latency in cycles with mem_ready always high: R/I = 4, load = 5, store = 4, branch = 3.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH;
  - state enum;
  - ALUOp encodings;
  - ALUSrcB encodings.
- One sub-module, ctrl_word_decode: combinational state -> control word. The FSM, opcode latch, trap and counter stay in the top module.

Test Plan:
- R-type 0110011, mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALU_WB; RegWrite=1 only in cycle 4; ALUOp=10 in cycle 3; retired 0 -> 1.
- Load 0000011 with mem_ready low for 3 cycles in MEM_RD -> MemRead=1, IorD=1 held for 4 cycles; MEM_WB has RegWrite=1, MemtoReg=1; total 8 cycles; retired +1.
- Store 0100011 then branch 1100011 -> MemWrite=1 for exactly 1 cycle; BRANCH has Branch=1, PCSource=1, ALUOp=01; retired +2 over 7 cycles.
- Opcode 1111111 -> TRAP after DECODE; illegal=1 and all controls 0 for 10+ cycles despite opcode changes; retired unchanged; reset clears illegal.
- Reset asserted in MEM_RD -> outputs 0 during reset; FETCH on the first cycle after release; retired reset to 0.
- CNT_W=4, 16 back-to-back I-type 0010011 -> retired wraps 15 -> 0; each EXEC_I has ALUSrcB=10, ALUOp=11.
